// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: N-requester round-robin arbiter with a registered one-hot
// grant. The owner keeps the grant until it pulses rel or drops its request.
// Optional hold-timeout preemption is compiled in with RR_ARB_HOLD_TIMEOUT_EN,
// which adds the hold_cnt register and the preempted output.
// `release` is a reserved word in SystemVerilog, so the owner's end-of-tenure
// strobe is named rel.
// Handshake: req[i] is a level request; grant[i] is valid from the edge after
// selection; the owner ends its tenure by asserting rel for one cycle or by
// dropping req[i]. The grant then moves (or clears) at the next edge.
// dbg_owned / dbg_ptr expose the FSM state and the next-priority pointer.
module rr_arbiter_lock #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rel,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    output logic             preempted,
`endif
    output logic             dbg_owned,
    output logic [IDX_W-1:0] dbg_ptr
);

    // Elaboration-time guard on the legal parameter ranges.
    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_arbiter_lock: N out of range 2..32");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_lock: MAX_HOLD out of range 1..255");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [N-1:0]     grant_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] owner_next_ptr;
    logic [IDX_W-1:0] scan_start;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             tenure_end;
    logic             new_grant;
    int               scan_d;
    int               best_d;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    logic [7:0]       hold_cnt, hold_nxt;
    logic             timeout_end;
    logic             preempted_nxt;
`endif

    assign grant_valid = |grant;
    assign dbg_owned   = (state == ST_OWNED);
    assign dbg_ptr     = ptr;

    // Winner search: the set req bit with the smallest forward distance from
    // scan_start (modulo N). During tenure the scan starts just past the owner
    // so the owner is considered last.
    always_comb begin
        owner_next_ptr = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        scan_start     = (state == ST_OWNED) ? owner_next_ptr : ptr;
        win_found      = 1'b0;
        win_idx        = '0;
        best_d         = N;
        scan_d         = 0;
        for (int k = 0; k < N; k++) begin
            scan_d = k - int'(scan_start);
            if (scan_d < 0) scan_d = scan_d + N;
            if (req[k] && scan_d < best_d) begin
                best_d    = scan_d;
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end

    // Next-state, next-grant and pointer update for the IDLE/OWNED FSM.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        idx_nxt    = grant_idx;
        new_grant  = 1'b0;
        tenure_end = 1'b0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        timeout_end   = 1'b0;
        preempted_nxt = 1'b0;
        hold_nxt      = hold_cnt;
`endif
        if (state == ST_OWNED) begin
            tenure_end = rel || !req[grant_idx];
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            // Timeout only matters when someone else is waiting.
            timeout_end   = (hold_cnt == 8'(MAX_HOLD)) && ((req & ~grant) != '0);
            preempted_nxt = timeout_end && !tenure_end;
            tenure_end    = tenure_end || timeout_end;
`endif
        end
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_nxt = ST_OWNED;
                    new_grant = 1'b1;
                end
            end
            ST_OWNED: begin
                if (tenure_end) begin
                    ptr_nxt = owner_next_ptr;
                    if (win_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        grant_nxt = '0;
                        idx_nxt   = '0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (new_grant) begin
            grant_nxt          = '0;
            grant_nxt[win_idx] = 1'b1;
            idx_nxt            = win_idx;
        end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        if (new_grant) begin
            hold_nxt = 8'd1;
        end else if (state_nxt == ST_IDLE) begin
            hold_nxt = 8'd0;
        end else if (hold_cnt != 8'(MAX_HOLD)) begin
            hold_nxt = hold_cnt + 8'd1;
        end
`endif
    end

    // State, grant and pointer registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_idx <= '0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt  <= 8'd0;
            preempted <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
            preempted <= preempted_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// tb_rr_arbiter_lock: hand-computed vector table, hand-written multi-cycle
// sequences, then random traffic checked against a behavioural model.
// Honours RR_ARB_HOLD_TIMEOUT_EN the same way the design does.
module tb_rr_arbiter_lock;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDX_W    = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             rel;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             dbg_owned;
    logic [IDX_W-1:0] dbg_ptr;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    logic             preempted;
`endif

    rr_arbiter_lock #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rel         (rel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        .preempted   (preempted),
`endif
        .dbg_owned   (dbg_owned),
        .dbg_ptr     (dbg_ptr)
    );

    // Clock and initial reset levels.
    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic drive(input logic r_n, input logic [N-1:0] r, input logic rl);
        @(negedge clk);
        rst_n = r_n;
        req   = r;
        rel   = rl;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: owner index (-1 = none), priority pointer, tenure length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_pre   = 0;

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int d = 0; d < N; d++) begin
            int k;
            k = (start + d) % N;
            if (r[k[IDX_W-1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_n, input logic [N-1:0] r, input logic rl);
        int  w;
        bit  others;
        bit  ends;
        bit  timeout;
        m_pre = 0;
        if (!r_n) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin m_owner = w; m_hold = 1; end
        end else begin
            others = 0;
            for (int i = 0; i < N; i++)
                if (i != m_owner && r[i[IDX_W-1:0]]) others = 1;
            ends    = rl || !r[m_owner[IDX_W-1:0]];
            timeout = 0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            timeout = (m_hold == MAX_HOLD) && others;
`endif
            if (ends || timeout) begin
                m_pre   = (timeout && !ends) ? 1 : 0;
                m_ptr   = (m_owner + 1) % N;
                w       = pick(r, m_ptr);
                m_owner = w;
                m_hold  = (w >= 0) ? 1 : 0;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
        exp_q.push_back((m_owner >= 0) ? N'(1) << m_owner : N'(0));
    endtask

    typedef struct {
        logic         r_n;
        logic [N-1:0] r;
        logic         rl;
        logic [N-1:0] e_grant;
        int           e_idx;
        int           e_ptr;
    } vec_t;

    vec_t vecs[22];

    initial begin
        logic [N-1:0] exp_g;
        logic [N-1:0] rr;

        // Values after each edge, worked out by hand.
        vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 0, 0}; // reset held with requests
        vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 0, 0};
        vecs[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 0, 0}; // first grant after reset
        vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1, 1}; // rotation
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2, 2};
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 3, 3};
        vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 0, 0};
        vecs[7]  = '{1'b1, 4'b0101, 1'b0, 4'b0001, 0, 0}; // hold
        vecs[8]  = '{1'b1, 4'b0101, 1'b0, 4'b0001, 0, 0};
        vecs[9]  = '{1'b1, 4'b0101, 1'b0, 4'b0001, 0, 0};
        vecs[10] = '{1'b1, 4'b0101, 1'b1, 4'b0100, 2, 1}; // handover, no gap
        vecs[11] = '{1'b1, 4'b0110, 1'b1, 4'b0010, 1, 3}; // scan from 3 wraps to 1
        vecs[12] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 0, 2}; // owner drops
        vecs[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 0, 2};
        vecs[14] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 0, 2}; // rel in idle ignored, scan from 2
        vecs[15] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 0, 2};
        vecs[16] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 2, 1}; // owner 2
        vecs[17] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 0, 0}; // mid-tenure reset
        vecs[18] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2, 0};
        vecs[19] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2, 0};
        vecs[20] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 2, 3}; // sole requester re-granted
        vecs[21] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 0, 3};

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].r_n, vecs[i].r, vecs[i].rl);
            check($sformatf("vec%0d grant", i), int'(grant), int'(vecs[i].e_grant));
            check($sformatf("vec%0d idx", i), int'(grant_idx), vecs[i].e_idx);
            check($sformatf("vec%0d valid", i), int'(grant_valid), int'(vecs[i].e_grant != 0));
            check($sformatf("vec%0d ptr", i), int'(dbg_ptr), vecs[i].e_ptr);
        end

        // Long tenure with a competitor waiting.
        drive(1'b0, 4'b0000, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 4'b0011, 1'b0);
            check($sformatf("hold c%0d grant", c), int'(grant), 1);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            check($sformatf("hold c%0d preempted", c), int'(preempted), 0);
`endif
        end
        drive(1'b1, 4'b0011, 1'b0);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        check("timeout grant", int'(grant), 2);
        check("timeout preempted", int'(preempted), 1);
        check("timeout ptr", int'(dbg_ptr), 1);
        drive(1'b1, 4'b0011, 1'b0);
        check("after timeout grant", int'(grant), 2);
        check("after timeout preempted", int'(preempted), 0);
`else
        check("unbounded grant", int'(grant), 1);
        check("unbounded ptr", int'(dbg_ptr), 0);
`endif

        // Sole requester keeps the grant indefinitely.
        drive(1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 4'b0001, 1'b0);
            check($sformatf("sole c%0d grant", c), int'(grant), 1);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            check($sformatf("sole c%0d preempted", c), int'(preempted), 0);
`endif
        end

        // Random traffic against the model.
        drive(1'b0, 4'b0000, 1'b0);
        m_owner = -1; m_ptr = 0; m_hold = 0; m_pre = 0;
        for (int c = 0; c < 400; c++) begin
            logic rn;
            logic rl;
            rr = N'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) rr[m_owner[IDX_W-1:0]] = 1'b1;
            rl = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 49) != 0);
            drive(rn, rr, rl);
            model_step(rn, rr, rl);
            exp_g = exp_q.pop_front();
            check($sformatf("rand%0d grant", c), int'(grant), int'(exp_g));
            check($sformatf("rand%0d idx", c), int'(grant_idx), (m_owner >= 0) ? m_owner : 0);
            check($sformatf("rand%0d valid", c), int'(grant_valid), int'(exp_g != 0));
            check($sformatf("rand%0d ptr", c), int'(dbg_ptr), m_ptr);
`ifdef RR_ARB_HOLD_TIMEOUT_EN
            check($sformatf("rand%0d preempted", c), int'(preempted), m_pre);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_lock.md
# rr_arbiter_lock

Parametrised N-requester round-robin arbiter with registered one-hot grant and multi-cycle ownership. A granted requester keeps the grant until it asserts `release` or drops its request; an optional hold limit preempts long owners. Sits in front of shared single-port resources (bus, memory port, pipeline slot) where requesters need the grant held over several cycles.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, default 8: maximum grant tenure in cycles; legal range 1..255. Used only with the hold-timeout feature.
- `IDX_W`, default `$clog2(N)`: width of `grant_idx`. Derived; never overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N  request vector; bit i = requester i.
- `release`  in  1  current owner ends its tenure this cycle.
- `grant`  out  N  registered one-hot grant, or all zeros.
- `grant_valid`  out  1  equals `|grant`.
- `grant_idx`  out  IDX_W  index of the granted requester; 0 when `grant_valid` = 0.
- `preempted`  out  1  one-cycle pulse; hold timeout forced a handover. Present only with `RR_ARB_HOLD_TIMEOUT_EN`.

## Operation
- State: `IDLE` (no owner) and `OWNED` (one owner).
- Internal registers:
  - `ptr`: IDX_W bits, next-priority index.
  - `hold_cnt`: 8 bits; only with the macro.
- Winner selection: the first set bit of `req` scanning from `ptr` upward, wrapping modulo N.
- `IDLE`:
  - `req` = 0: stay in `IDLE`.
  - `req` != 0: register the winner, go to `OWNED`.
- `OWNED`, end of tenure. Tenure ends in the cycle any of these holds:
  - `release` = 1;
  - `req[owner]` = 0;
  - hold timeout fires (macro only; see Configuration).
- At end of tenure:
  - `ptr` <= (owner + 1) mod N.
  - A new winner is selected from the same cycle's `req`, scanning from (owner + 1) mod N. The old owner is therefore considered last.
  - If a winner exists, its grant is registered directly (back-to-back, no idle cycle). Otherwise go to `IDLE`.
  - The same owner is re-granted if it is the only requester and the tenure ended only by `release`.
- `release` in `IDLE` is ignored.
- `release` has no effect on a requester that is not the owner.
- `ptr` changes only at end of tenure.
- `grant` is always one-hot or zero. A grant never goes to a requester whose `req` bit was 0 in the selection cycle.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - `grant` = 0, `grant_valid` = 0, `grant_idx` = 0, `preempted` = 0.
  - `ptr` = 0, `hold_cnt` = 0, state `IDLE`.
- Reset asserted mid-tenure drops the grant at that edge. It takes priority over all other events.
- Grant latency: a request seen at edge k is granted from edge k+1 (one cycle).
- Handover latency: when tenure ends at edge k, the new grant is visible after edge k+1. No gap cycle and no overlap.
- Deasserting `req[owner]` at edge k removes the grant after edge k+1. A requester may therefore see its grant for one cycle after dropping its request.
- Outputs are all registered. No combinational path from inputs to outputs.

## Configuration
- Macro: `RR_ARB_HOLD_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` loads 1 on each new grant and increments each `OWNED` cycle, saturating at `MAX_HOLD`.
  - If `hold_cnt` == `MAX_HOLD` and some other `req` bit is set, tenure ends: handover as above, and `preempted` pulses high in the first cycle of the new grant.
  - If `hold_cnt` == `MAX_HOLD` and no other requester is pending, the owner keeps the grant and the counter stays saturated.
- Not defined:
  - No `hold_cnt` register and no `preempted` port.
  - Tenure is unbounded; only `release` or request drop ends it.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- Reset: `rst_n`=0 with `req`=4'b1111 -> `grant`=0, `grant_valid`=0 and `grant_idx`=0 every cycle while held. First grant after reset release is 4'b0001 one cycle later.
- Rotation: `req`=4'b1111 held, `release` pulsed every cycle -> `grant` sequence 0001, 0010, 0100, 1000, 0001.
- Hold: `req`=4'b0101, owner 0, `release`=0 for 3 cycles -> `grant`=0001 stays. After `release` -> `grant`=0100 next cycle with no gap cycle, `ptr`=1.
- Skip and wrap: `ptr`=3, `req`=4'b0110 -> `grant`=0010 (index wraps past 3 and 0). `req`=0 thereafter -> `grant`=0 one cycle after the owner drops its request.
- Timeout (macro defined): `req`=4'b0011, no `release` -> `grant`=0001 for 4 cycles, then 0010 with `preempted`=1 for one cycle. With `req`=4'b0001 only, the grant is held indefinitely and `preempted` stays 0.
- Mid-tenure reset: owner 2 granted, `rst_n`=0 for one cycle -> `grant`=0 after that edge, `ptr`=0. With `req`=4'b0100 still set, the next grant is 0100 one cycle after reset deasserts.
